// File: rtl/div_share_sched.sv
// Round-robin front end for one shared, fixed-latency pipelined divider.
// Registers the granted operands and tracks each issue with a tag pipeline.
module div_share_sched #(
  parameter int NUM_REQ = 4,
  parameter int WD0     = 64,
  parameter int WD1     = 32,
  parameter int DIV_LAT = WD0 + 1,
  parameter int IDW     = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_en,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*WD0-1:0]       req_a,
  input  logic [NUM_REQ*WD1-1:0]       req_b,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [WD0-1:0]               div_a,
  output logic [WD1-1:0]               div_b,
  input  logic [WD0-1:0]               div_result,
  output logic                         res_valid,
  output logic [IDW-1:0]               res_id,
  output logic [WD0-1:0]               res_quot,
  output logic                         res_div0,
  output logic [$clog2(DIV_LAT+2):0]   inflight,
  output logic                         idle
);

  localparam int INF_W = $clog2(DIV_LAT + 2) + 1;
  localparam int TAGS  = DIV_LAT + 1;

  function automatic logic [WD0-1:0] force_div0(input logic [WD0-1:0] q, input logic z);
    force_div0 = z ? '1 : q;
  endfunction

  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     gnt_id;
  logic [NUM_REQ-1:0] gnt_oh;
  logic               gnt_found;
  logic               accept;
  logic [WD0-1:0]     sel_a;
  logic [WD1-1:0]     sel_b;
  logic               sel_zero;
  logic [INF_W-1:0]   inflight_d;

  logic               tag_vld_q [TAGS];
  logic [IDW-1:0]     tag_id_q  [TAGS];
  logic               tag_z_q   [TAGS];

  // Grant: the second pass (at/after the pointer) overrides the wrap-around pass.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    gnt_oh    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(i);
        gnt_oh    = '0;
        gnt_oh[i] = 1'b1;
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (IDW'(i) >= ptr_q)) begin
        gnt_id    = IDW'(i);
        gnt_oh    = '0;
        gnt_oh[i] = 1'b1;
      end
    end
    if (!issue_en || rst) begin
      gnt_found = 1'b0;
      gnt_oh    = '0;
    end
  end

  assign req_ready = gnt_oh;
  assign accept    = gnt_found;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i]) begin
        sel_a = req_a[i*WD0 +: WD0];
        sel_b = req_b[i*WD1 +: WD1];
      end
    end
    sel_zero = (sel_b == '0);
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + IDW'(1);
    end
  end

  always_comb begin
    inflight_d = inflight;
    case ({accept, tag_vld_q[TAGS-1]})
      2'b10:   inflight_d = inflight + INF_W'(1);
      2'b01:   inflight_d = inflight - INF_W'(1);
      default: inflight_d = inflight;
    endcase
  end

  assign idle = (inflight == '0) && !accept;

  // Issue stage and result stage: control plus the operand/result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      div_a     <= '0;
      div_b     <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_quot  <= '0;
      res_div0  <= 1'b0;
      inflight  <= '0;
      for (int j = 0; j < TAGS; j++) tag_vld_q[j] <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      if (accept) begin
        div_a <= sel_a;
        div_b <= sel_b;
      end
      tag_vld_q[0] <= accept;
      for (int j = 1; j < TAGS; j++) tag_vld_q[j] <= tag_vld_q[j-1];
      res_valid <= tag_vld_q[TAGS-1];
      res_id    <= tag_id_q[TAGS-1];
      res_div0  <= tag_z_q[TAGS-1];
      res_quot  <= force_div0(div_result, tag_z_q[TAGS-1]);
      inflight  <= inflight_d;
    end
  end

  // Tag payload stages: qualified by tag_vld_q, so no reset needed.
  always_ff @(posedge clk) begin
    tag_id_q[0] <= gnt_id;
    tag_z_q[0]  <= sel_zero;
    for (int j = 1; j < TAGS; j++) begin
      tag_id_q[j] <= tag_id_q[j-1];
      tag_z_q[j]  <= tag_z_q[j-1];
    end
  end

endmodule

// File: doc/div_share_sched.md
Name: div_share_sched

Overview:
- Round-robin scheduler that shares one fully pipelined shift-subtract divider (quotient width WD0, divisor width WD1, one issue per clock, fixed latency, no valid or reset of its own) among NUM_REQ requesters.
- Registers the chosen operands onto the divider inputs and carries a valid/requester-id/div-by-zero tag down a shift pipeline matched to the divider latency.
- Returns each quotient, tagged, on a shared result bus.
- Sits between the SGBM cost-aggregation/normalisation units and the shared divider instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WD0, 64, dividend and quotient width; equals the divider's WidthD0.
- WD1, 32, divisor width; equals the divider's WidthD1.
- DIV_LAT, WD0+1, clocks from div_a/div_b change to the matching div_result.
- IDW, 3, requester id width; must be at least clog2(NUM_REQ).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- issue_en  in  1  when 0, no new grant is made
- req_valid  in  NUM_REQ  per-requester request
- req_a  in  NUM_REQ*WD0  dividends, requester i at [i*WD0 +: WD0]
- req_b  in  NUM_REQ*WD1  divisors, requester i at [i*WD1 +: WD1]
- req_ready  out  NUM_REQ  one-hot grant; accept = req_valid[i] & req_ready[i]
- div_a  out  WD0  dividend to divider, registered
- div_b  out  WD1  divisor to divider, registered
- div_result  in  WD0  quotient from divider
- res_valid  out  1  result strobe, one cycle per accepted request
- res_id  out  IDW  requester index of the result
- res_quot  out  WD0  quotient
- res_div0  out  1  divisor was zero; res_quot forced to all-ones
- inflight  out  clog2(DIV_LAT+2)+1  requests accepted but not yet returned
- idle  out  1  inflight==0 and no accept this cycle

Behaviour:
- Reset (rst=1 at a clock edge):
  - res_valid=0, res_id=0, res_quot=0, res_div0=0, div_a=0, div_b=0, inflight=0, RR pointer=0.
  - All tag-pipeline valid bits cleared. The divider keeps computing; its outputs are ignored.
  - Reset mid-operation therefore drops every in-flight result; no res_valid appears for pre-reset requests.
  - req_ready=0 while rst=1.
- Grant (combinational):
  - If issue_en=1, pick the first i with req_valid[i]=1, searching from the RR pointer upward with wrap. Drive req_ready one-hot for that i only.
  - If no requester is valid or issue_en=0, req_ready=0.
  - req_ready never depends on res_valid; the result bus has no backpressure and consumers must sink one result per cycle.
- On accept at edge k:
  - Load div_a<=req_a[i] and div_b<=req_b[i].
  - Push tag {1, i, req_b[i]==0} into tag stage 0.
  - Set the pointer to (i+1) mod NUM_REQ.
  - With no accept, div_a/div_b hold their values, the pushed tag valid=0, and the pointer holds.
- Tag pipeline:
  - DIV_LAT+1 register stages, shifting every cycle with no stall.
  - At edge k+DIV_LAT+1: res_valid<=tag.valid, res_id<=tag.id, res_div0<=tag.div0.
  - At the same edge, res_quot<=div_result, or all-ones if div0 (the raw divider already yields all-ones for b=0; the forcing is explicit).
  - Latency from accept edge to res_valid high: DIV_LAT+1 clocks. Sustained throughput: one result per cycle.
- inflight counter:
  - +1 on accept, -1 on res_valid load, unchanged when both occur in the same cycle.
  - Never exceeds DIV_LAT+1.
- Ordering: results are strictly in accept order, independent of requester.
- Quotient is unsigned floor(a/b), WD0 bits. The block does no range checking beyond div0.
- A requester holding req_valid with changing operands gets the values sampled on its accept edge.
- Simultaneous rst and accept: rst wins; the accept is lost (req_ready=0 under rst anyway).

Test Plan:
(WD0=8, WD1=4, DIV_LAT=9, NUM_REQ=4)
- Single request: req 2 presents a=100, b=7 at edge 0 with issue_en=1 → req_ready=4'b0100; res_valid=1, res_id=2, res_quot=14, res_div0=0 after edge 10; inflight 1 during cycles 1-10, 0 after.
- Fairness: all four requesters hold valid for 8 cycles → grants 0,1,2,3,0,1,2,3. Results return back-to-back in that order, one per cycle, quotients matching floor(a/b).
- Divide by zero: a=55, b=0 → res_div0=1, res_quot=8'hFF, correct id.
- issue_en low: issue_en=0 for 5 cycles with requests pending → req_ready=0 and no tags pushed. When raised, grant resumes from the unchanged pointer.
- Reset mid-flight: accept 3 requests, assert rst for 1 cycle at edge 4 → no res_valid for those 3, inflight=0, pointer=0. A request issued after reset returns correct in DIV_LAT+1 clocks.
- Boundary: a=255, b=1 → 255; a=0, b=15 → 0; a=14, b=15 → 0; a=255, b=15 → 17.
